// File: rtl/lsu_pkg.sv
// Shared constants, FSM encoding and decode helpers for the RV32 load/store stage.
package lsu_pkg;

    localparam logic [2:0] F3_B       = 3'b000;
    localparam logic [2:0] F3_H       = 3'b001;
    localparam logic [2:0] F3_W       = 3'b010;
    localparam logic [2:0] F3_BU      = 3'b100;
    localparam logic [2:0] F3_HU      = 3'b101;
    localparam logic [2:0] RWTYP_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    // Anything that is not a byte or halfword op (including reserved encodings) is a word op.
    function automatic logic is_word_op(input logic [2:0] f3);
        return !(f3 == F3_B || f3 == F3_BU || f3 == F3_H || f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == F3_B || f3 == F3_BU) return 1'b0;
        if (f3 == F3_H || f3 == F3_HU) return a[0];
        return a != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/response handshake and word-RAM bus of the load/store stage.
// req and resp both follow valid/ready: a transfer happens on the rising edge where
// valid && ready; a raised valid and its payload stay stable until that edge.
interface lsu_mem_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [2:0]            ram_rwtyp;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_wren;
    logic                  ram_rden;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, ram_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_rwtyp, ram_addr, ram_wdata, ram_wren, ram_rden
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, ram_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_rwtyp, ram_addr, ram_wdata, ram_wren, ram_rden
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and byte/halfword store merge into a word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [4:0]  b_shamt;
    logic [4:0]  h_shamt;
    logic [31:0] b_shifted;
    logic [31:0] h_shifted;
    logic [31:0] b_mask;
    logic [31:0] h_mask;

    assign b_shamt   = {addr_i, 3'b000};
    assign h_shamt   = {addr_i[1], 4'b0000};
    assign b_shifted = word_i >> b_shamt;
    assign h_shifted = word_i >> h_shamt;
    assign b_mask    = 32'h0000_00FF << b_shamt;
    assign h_mask    = 32'h0000_FFFF << h_shamt;

    always_comb begin
        load_o  = word_i;
        store_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                load_o  = {{24{b_shifted[7]}}, b_shifted[7:0]};
                store_o = (word_i & ~b_mask) | ({24'd0, wdata_i[7:0]} << b_shamt);
            end
            F3_BU: load_o = {24'd0, b_shifted[7:0]};
            F3_H: begin
                load_o  = {{16{h_shifted[15]}}, h_shifted[15:0]};
                store_o = (word_i & ~h_mask) | ({16'd0, wdata_i[15:0]} << h_shamt);
            end
            F3_HU: load_o = {16'd0, h_shifted[15:0]};
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// RV32 load/store stage: word RAM accesses, RMW for SB/SH, aligned/extended load results.
// Build option: define LSU_MISALIGN_CHECK_EN to flag misaligned requests with resp_err.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_stage_if.slave bus,
    output lsu_state_e    state_o
);
    lsu_state_e            state_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;
    logic                  ram_rden_q;
    logic                  ram_wren_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    logic                  req_misaligned;
    logic [31:0]           load_word;
    logic [31:0]           store_word;

`ifdef LSU_MISALIGN_CHECK_EN
    assign req_misaligned = misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    lsu_lane_align u_align (
        .funct3_i (funct3_q),
        .addr_i   (addr_q[1:0]),
        .word_i   (bus.ram_q),
        .wdata_i  (wdata_q),
        .load_o   (load_word),
        .store_o  (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_rden_q   <= 1'b0;
            ram_wren_q   <= 1'b0;
            ram_wdata_q  <= '0;
        end else begin
            // Strobes are single-cycle pulses unless a transition below raises them.
            ram_rden_q <= 1'b0;
            ram_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q         <= bus.req_we;
                        funct3_q     <= bus.req_funct3;
                        addr_q       <= bus.req_addr;
                        wdata_q      <= bus.req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        if (req_misaligned) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (bus.req_we && is_word_op(bus.req_funct3)) begin
                            ram_wdata_q <= bus.req_wdata;
                            ram_wren_q  <= 1'b1;
                            state_q     <= WRITE;
                        end else begin
                            ram_rden_q <= 1'b1;
                            state_q    <= READ;
                        end
                    end
                end
                READ: state_q <= CAPT;
                CAPT: begin
                    if (we_q) begin
                        ram_wdata_q <= store_word;
                        ram_wren_q  <= 1'b1;
                        state_q     <= WRITE;
                    end else begin
                        resp_rdata_q <= load_word;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.ram_rwtyp  = RWTYP_WORD;
    assign bus.ram_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.ram_rden   = ram_rden_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a small synchronous word-RAM model.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    lsu_state_e state;
    int         cmp_cnt = 0;
    int         err_cnt = 0;
    int         rd_tot = 0;
    int         wr_tot = 0;
    int         both_cnt = 0;
    int         rd_base;
    int         wr_base;
    logic [31:0] last_wdata = '0;
    logic [31:0] mem [0:255];

    lsu_mem_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    lsu_mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if.slave),
        .state_o (state)
    );

    always #5 clk = ~clk;

    // RAM model: read data appears the cycle after ram_rden, zero otherwise.
    always @(posedge clk) begin
        bus_if.ram_q <= bus_if.ram_rden ? mem[bus_if.ram_addr[9:2]] : 32'd0;
        if (bus_if.ram_wren) begin
            mem[bus_if.ram_addr[9:2]] <= bus_if.ram_wdata;
            last_wdata <= bus_if.ram_wdata;
            wr_tot <= wr_tot + 1;
        end
        if (bus_if.ram_rden) rd_tot <= rd_tot + 1;
        if (bus_if.ram_rden && bus_if.ram_wren) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall,
                          output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        rd_base = rd_tot;
        wr_base = wr_tot;
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus_if.resp_valid) break;
        end
        if (!bus_if.resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rdata = bus_if.resp_rdata;
        err   = bus_if.resp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
            check("stall_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
        end
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.resp_ready = 1'b0;
    endtask

    int          lat;
    logic [31:0] rdata;
    logic        err;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_state", {29'd0, state}, {29'd0, IDLE});
        check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, bus_if.resp_err}, 32'd0);
        check("rst_strobes", {30'd0, bus_if.ram_wren, bus_if.ram_rden}, 32'd0);
        check("rwtyp", {29'd0, bus_if.ram_rwtyp}, 32'd2);

        mem[32'h100 >> 2] = 32'h8041_C2F3;
        do_req(1'b0, F3_B, 32'h101, 32'd0, 0, lat, rdata, err);
        check("lb_101", rdata, 32'hFFFF_FFC2);
        check("lb_lat", lat, 3);
        check("lb_err", {31'd0, err}, 32'd0);
        check("lb_rd_cnt", rd_tot - rd_base, 1);
        do_req(1'b0, F3_BU, 32'h101, 32'd0, 0, lat, rdata, err);
        check("lbu_101", rdata, 32'h0000_00C2);
        do_req(1'b0, F3_B, 32'h100, 32'd0, 0, lat, rdata, err);
        check("lb_100", rdata, 32'hFFFF_FFF3);
        do_req(1'b0, F3_BU, 32'h103, 32'd0, 0, lat, rdata, err);
        check("lbu_103", rdata, 32'h0000_0080);
        do_req(1'b0, F3_H, 32'h102, 32'd0, 0, lat, rdata, err);
        check("lh_102", rdata, 32'hFFFF_8041);
        do_req(1'b0, F3_HU, 32'h102, 32'd0, 0, lat, rdata, err);
        check("lhu_102", rdata, 32'h0000_8041);
        do_req(1'b0, F3_H, 32'h100, 32'd0, 0, lat, rdata, err);
        check("lh_100", rdata, 32'hFFFF_C2F3);
        do_req(1'b0, F3_W, 32'h100, 32'd0, 0, lat, rdata, err);
        check("lw_100", rdata, 32'h8041_C2F3);
        check("lw_lat", lat, 3);

        mem[32'h100 >> 2] = 32'h1122_3344;
        do_req(1'b1, F3_B, 32'h103, 32'h0000_00AB, 0, lat, rdata, err);
        check("sb_lat", lat, 4);
        check("sb_rd_cnt", rd_tot - rd_base, 1);
        check("sb_wr_cnt", wr_tot - wr_base, 1);
        check("sb_wdata", last_wdata, 32'hAB22_3344);
        check("sb_rdata", rdata, 32'd0);
        do_req(1'b0, F3_W, 32'h100, 32'd0, 0, lat, rdata, err);
        check("lw_after_sb", rdata, 32'hAB22_3344);
        do_req(1'b1, F3_H, 32'h102, 32'hFFFF_55AA, 0, lat, rdata, err);
        check("sh_lat", lat, 4);
        check("sh_mem", mem[32'h100 >> 2], 32'h55AA_3344);
        do_req(1'b1, F3_B, 32'h100, 32'h0000_0077, 0, lat, rdata, err);
        check("sb_100_mem", mem[32'h100 >> 2], 32'h55AA_3377);

        do_req(1'b1, F3_W, 32'h200, 32'hDEAD_BEEF, 5, lat, rdata, err);
        check("sw_lat", lat, 2);
        check("sw_rd_cnt", rd_tot - rd_base, 0);
        check("sw_wr_cnt", wr_tot - wr_base, 1);
        check("sw_mem", mem[32'h200 >> 2], 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_after_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("sw_after_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        do_req(1'b0, 3'b011, 32'h200, 32'd0, 0, lat, rdata, err);
        check("f3_011_as_w", rdata, 32'hDEAD_BEEF);

        do_req(1'b0, F3_W, 32'h102, 32'd0, 0, lat, rdata, err);
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_err", {31'd0, err}, 32'd1);
        check("mis_lat", lat, 1);
        check("mis_strobes", (rd_tot - rd_base) + (wr_tot - wr_base), 0);
`else
        check("mis_err", {31'd0, err}, 32'd0);
        check("mis_lat", lat, 3);
        check("mis_rdata", rdata, 32'h55AA_3377);
`endif

        // Reset lands while an SH sits in CAPT: the write must never happen.
        mem[32'h300 >> 2] = 32'h1234_5678;
        wr_base = wr_tot;
        @(negedge clk);
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = 1'b1;
        bus_if.req_funct3 = F3_H;
        bus_if.req_addr   = 32'h302;
        bus_if.req_wdata  = 32'h0000_9999;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_capt", {29'd0, state}, {29'd0, CAPT});
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_state", {29'd0, state}, {29'd0, IDLE});
        check("rst_mid_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("rst_mid_wren", {31'd0, bus_if.ram_wren}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_wr_cnt", wr_tot - wr_base, 0);
        check("rst_mid_mem", mem[32'h300 >> 2], 32'h1234_5678);

        check("strobe_overlap", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
